axis_slip_decoder: RTL and testbench

AXIS_SLIP_DECODER -- requirements
Module: axis_slip_decoder

---
 rtl/axis_slip_decoder.sv | 181 ++++++++++++++++++
 tb/tb_axis_slip_decoder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_slip_decoder.sv
// SLIP frame decoder: raw byte stream in, decoded AXI-Stream bytes out with
// tlast on the frame delimiter and tuser marking aborted frames.
module axis_slip_decoder #(
    parameter int unsigned MAX_FRAME_BYTES = 256,
    parameter logic [7:0]  END_CHAR        = 8'hC0,
    parameter logic [7:0]  ESC_CHAR        = 8'hDB,
    parameter logic [7:0]  ESC_END         = 8'hDC,
    parameter logic [7:0]  ESC_ESC         = 8'hDD
) (
    input  logic        clk,
    input  logic        sresetn,
    output logic        s_axis_tready,
    input  logic        s_axis_tvalid,
    input  logic [7:0]  s_axis_tdata,
    input  logic        m_axis_tready,
    output logic        m_axis_tvalid,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        frame_error,
    output logic [15:0] error_count
);

    localparam int unsigned CW      = $clog2(MAX_FRAME_BYTES + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_FRAME_BYTES);

    typedef enum logic [1:0] {
        NORMAL,
        ESCAPE,
        DISCARD
    } state_t;

    state_t          state, state_nxt;
    logic            hold_valid, hold_valid_nxt;
    logic [7:0]      hold_data, hold_data_nxt;
    logic [CW-1:0]   byte_cnt, byte_cnt_nxt;

    logic            out_valid;
    logic [7:0]      out_data;
    logic            out_last;
    logic            out_user;

    logic            accept;
    logic            dec_valid;
    logic [7:0]      dec_byte;
    logic            abort;
    logic            load;
    logic            ld_last;
    logic            ld_user;

    assign s_axis_tready = !out_valid || m_axis_tready;
    assign accept        = s_axis_tvalid && s_axis_tready;

    assign m_axis_tvalid = out_valid;
    assign m_axis_tdata  = out_data;
    assign m_axis_tlast  = out_last;
    assign m_axis_tuser  = out_user;

    always_comb begin
        state_nxt      = state;
        hold_valid_nxt = hold_valid;
        hold_data_nxt  = hold_data;
        byte_cnt_nxt   = byte_cnt;
        dec_valid      = 1'b0;
        dec_byte       = s_axis_tdata;
        abort          = 1'b0;
        load           = 1'b0;
        ld_last        = 1'b0;
        ld_user        = 1'b0;

        if (accept) begin
            unique case (state)
                NORMAL: begin
                    if (s_axis_tdata == END_CHAR) begin
                        if (hold_valid) begin
                            load    = 1'b1;
                            ld_last = 1'b1;
                        end
                        hold_valid_nxt = 1'b0;
                        byte_cnt_nxt   = '0;
                    end else if (s_axis_tdata == ESC_CHAR) begin
                        state_nxt = ESCAPE;
                    end else begin
                        dec_valid = 1'b1;
                    end
                end
                ESCAPE: begin
                    if (s_axis_tdata == ESC_END) begin
                        dec_valid = 1'b1;
                        dec_byte  = END_CHAR;
                        state_nxt = NORMAL;
                    end else if (s_axis_tdata == ESC_ESC) begin
                        dec_valid = 1'b1;
                        dec_byte  = ESC_CHAR;
                        state_nxt = NORMAL;
                    end else if (s_axis_tdata == END_CHAR) begin
                        abort     = 1'b1;
                        state_nxt = NORMAL;
                    end else begin
                        abort     = 1'b1;
                        state_nxt = DISCARD;
                    end
                end
                DISCARD: begin
                    if (s_axis_tdata == END_CHAR) begin
                        state_nxt = NORMAL;
                    end
                end
                default: state_nxt = NORMAL;
            endcase
        end

        // A decoded byte either pushes the previous one out or overflows the frame
        if (dec_valid) begin
            if (byte_cnt == MAX_CNT) begin
                abort     = 1'b1;
                state_nxt = DISCARD;
            end else begin
                if (hold_valid) begin
                    load = 1'b1;
                end
                hold_valid_nxt = 1'b1;
                hold_data_nxt  = dec_byte;
                byte_cnt_nxt   = byte_cnt + CW'(1);
            end
        end

        if (abort) begin
            if (hold_valid) begin
                load    = 1'b1;
                ld_last = 1'b1;
                ld_user = 1'b1;
            end
            hold_valid_nxt = 1'b0;
            byte_cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            state      <= NORMAL;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            byte_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            hold_valid <= hold_valid_nxt;
            hold_data  <= hold_data_nxt;
            byte_cnt   <= byte_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_user  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= hold_data;
            out_last  <= ld_last;
            out_user  <= ld_user;
        end else if (m_axis_tready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            frame_error <= 1'b0;
            error_count <= '0;
        end else begin
            frame_error <= abort;
            if (abort && (error_count != '1)) begin
                error_count <= error_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_axis_slip_decoder.sv
// Scoreboard bench for axis_slip_decoder: default instance plus a
// MAX_FRAME_BYTES=4 instance for the overflow boundary.
module tb_axis_slip_decoder;

    logic        clk = 1'b0;
    logic        sresetn;
    logic [7:0]  s_tdata;
    logic        s_tvalid0, s_tvalid1;
    logic        s_tready0, s_tready1;
    logic        m_tready0, m_tready1;
    logic        m_tvalid0, m_tvalid1;
    logic [7:0]  m_tdata0, m_tdata1;
    logic        m_tlast0, m_tlast1;
    logic        m_tuser0, m_tuser1;
    logic        frame_error0, frame_error1;
    logic [15:0] error_count0, error_count1;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned ferr0    = 0;
    int unsigned ferr1    = 0;
    int unsigned nout0    = 0;
    int unsigned viol     = 0;
    bit          rand_mode = 1'b0;

    logic [9:0]  q0[$];
    logic [9:0]  q1[$];

    always #5 clk = ~clk;

    axis_slip_decoder u_dut (
        .clk          (clk),
        .sresetn      (sresetn),
        .s_axis_tready(s_tready0),
        .s_axis_tvalid(s_tvalid0),
        .s_axis_tdata (s_tdata),
        .m_axis_tready(m_tready0),
        .m_axis_tvalid(m_tvalid0),
        .m_axis_tdata (m_tdata0),
        .m_axis_tlast (m_tlast0),
        .m_axis_tuser (m_tuser0),
        .frame_error  (frame_error0),
        .error_count  (error_count0)
    );

    axis_slip_decoder #(.MAX_FRAME_BYTES(4)) u_dut4 (
        .clk          (clk),
        .sresetn      (sresetn),
        .s_axis_tready(s_tready1),
        .s_axis_tvalid(s_tvalid1),
        .s_axis_tdata (s_tdata),
        .m_axis_tready(m_tready1),
        .m_axis_tvalid(m_tvalid1),
        .m_axis_tdata (m_tdata1),
        .m_axis_tlast (m_tlast1),
        .m_axis_tuser (m_tuser1),
        .frame_error  (frame_error1),
        .error_count  (error_count1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        m_tready0 = rand_mode ? ($urandom_range(0, 9) < 3) : 1'b1;
        m_tready1 = 1'b1;
    end

    always @(negedge clk) begin
        if (sresetn) begin
            if (m_tvalid0 && !m_tready0 && s_tready0) viol++;
            if (frame_error0) ferr0++;
            if (frame_error1) ferr1++;
            if (m_tvalid0 && m_tready0) begin
                nout0++;
                if (q0.size() == 0) check("unexpected_out0", {m_tuser0, m_tlast0, m_tdata0}, 10'h3FF);
                else check("out0", {m_tuser0, m_tlast0, m_tdata0}, q0.pop_front());
            end
            if (m_tvalid1 && m_tready1) begin
                if (q1.size() == 0) check("unexpected_out1", {m_tuser1, m_tlast1, m_tdata1}, 10'h3FF);
                else check("out1", {m_tuser1, m_tlast1, m_tdata1}, q1.pop_front());
            end
        end
    end

    task automatic send_byte(input int unsigned inst, input logic [7:0] b);
        bit          acc = 1'b0;
        int unsigned n   = 0;
        s_tdata = b;
        if (inst == 0) s_tvalid0 = 1'b1; else s_tvalid1 = 1'b1;
        while (!acc && n < 1000) begin
            @(negedge clk);
            acc = (inst == 0) ? s_tready0 : s_tready1;
            @(posedge clk);
            #1;
            n++;
        end
        s_tvalid0 = 1'b0;
        s_tvalid1 = 1'b0;
        if (!acc) check("send_timeout", {31'd0, acc}, 32'd1);
    endtask

    task automatic send_seq(input int unsigned inst, input logic [7:0] seq[$]);
        foreach (seq[i]) send_byte(inst, seq[i]);
    endtask

    // {user, last, data}
    task automatic exp0(input logic u, input logic l, input logic [7:0] d);
        q0.push_back({u, l, d});
    endtask

    task automatic exp1(input logic u, input logic l, input logic [7:0] d);
        q1.push_back({u, l, d});
    endtask

    task automatic drain(input string tag);
        int unsigned n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 100000) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_q0_empty"}, q0.size(), 0);
        check({tag, "_q1_empty"}, q1.size(), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  pay[$];
        logic [7:0]  b;
        int unsigned len;
        int unsigned nout_before;

        sresetn   = 1'b0;
        s_tdata   = '0;
        s_tvalid0 = 1'b0;
        s_tvalid1 = 1'b0;
        m_tready0 = 1'b1;
        m_tready1 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tvalid", {31'd0, m_tvalid0}, 0);
        check("rst_tdata", {24'd0, m_tdata0}, 0);
        check("rst_tlast", {31'd0, m_tlast0}, 0);
        check("rst_tuser", {31'd0, m_tuser0}, 0);
        check("rst_frame_error", {31'd0, frame_error0}, 0);
        check("rst_error_count", {16'd0, error_count0}, 0);
        @(posedge clk);
        #1;
        sresetn = 1'b1;
        @(negedge clk);
        check("rst_tready", {31'd0, s_tready0}, 1);
        @(posedge clk);
        #1;

        // plain frame with leading delimiter
        exp0(0, 0, 8'h01); exp0(0, 1, 8'h02);
        send_seq(0, '{8'hC0, 8'h01, 8'h02, 8'hC0});
        drain("basic");
        check("basic_err_count", {16'd0, error_count0}, 0);

        // escapes
        exp0(0, 0, 8'h01); exp0(0, 0, 8'hC0); exp0(0, 0, 8'hDB); exp0(0, 1, 8'h03);
        send_seq(0, '{8'h01, 8'hDB, 8'hDC, 8'hDB, 8'hDD, 8'h03, 8'hC0});
        drain("escape");
        check("escape_no_ferr", ferr0, 0);

        // empty frames
        nout_before = nout0;
        send_seq(0, '{8'hC0, 8'hC0, 8'hC0});
        drain("empty");
        check("empty_no_output", nout0, nout_before);
        check("empty_no_err", {16'd0, error_count0}, 0);

        // bad escape then discard
        exp0(1, 1, 8'h05); exp0(0, 1, 8'h09);
        send_seq(0, '{8'h05, 8'hDB, 8'h07, 8'h08, 8'hC0, 8'h09, 8'hC0});
        drain("badesc");
        check("badesc_ferr_pulses", ferr0, 1);
        check("badesc_err_count", {16'd0, error_count0}, 1);

        // escape followed by END: abort, delimiter consumed
        exp0(1, 1, 8'h0A); exp0(0, 1, 8'h0B);
        send_seq(0, '{8'h0A, 8'hDB, 8'hC0, 8'h0B, 8'hC0});
        drain("escend");
        check("escend_ferr_pulses", ferr0, 2);
        check("escend_err_count", {16'd0, error_count0}, 2);

        // overflow on the 4-byte instance
        exp1(0, 0, 8'h01); exp1(0, 0, 8'h02); exp1(0, 0, 8'h03); exp1(1, 1, 8'h04);
        send_seq(1, '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'hC0});
        drain("ovf");
        check("ovf_err_count", {16'd0, error_count1}, 1);
        check("ovf_ferr_pulses", ferr1, 1);
        exp1(0, 0, 8'h31); exp1(0, 0, 8'h32); exp1(0, 0, 8'h33); exp1(0, 1, 8'h34);
        send_seq(1, '{8'h31, 8'h32, 8'h33, 8'h34, 8'hC0});
        drain("fullframe");
        check("fullframe_err_count", {16'd0, error_count1}, 1);

        // reset mid-frame
        send_byte(0, 8'h0A);
        sresetn = 1'b0;
        @(negedge clk);
        check("midrst_tvalid", {31'd0, m_tvalid0}, 0);
        @(posedge clk);
        #1;
        sresetn = 1'b1;
        ferr0 = 0;
        nout_before = nout0;
        send_byte(0, 8'hC0);
        drain("midrst");
        check("midrst_no_output", nout0, nout_before);
        check("midrst_err_count", {16'd0, error_count0}, 0);
        exp0(0, 1, 8'h11);
        send_seq(0, '{8'h11, 8'hC0});
        drain("postrst");
        check("postrst_no_ferr", ferr0, 0);

        // random frames under random backpressure
        rand_mode = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            len = $urandom_range(0, 6);
            pay.delete();
            for (int k = 0; k < int'(len); k++) begin
                case ($urandom_range(0, 7))
                    0:       b = 8'hC0;
                    1:       b = 8'hDB;
                    default: b = 8'($urandom_range(0, 255));
                endcase
                pay.push_back(b);
                exp0(0, (k == int'(len) - 1), b);
            end
            foreach (pay[k]) begin
                if (pay[k] == 8'hC0) begin
                    send_byte(0, 8'hDB); send_byte(0, 8'hDC);
                end else if (pay[k] == 8'hDB) begin
                    send_byte(0, 8'hDB); send_byte(0, 8'hDD);
                end else begin
                    send_byte(0, pay[k]);
                end
            end
            send_byte(0, 8'hC0);
        end
        drain("random");
        rand_mode = 1'b0;
        check("random_err_count", {16'd0, error_count0}, 0);
        check("random_no_ferr", ferr0, 0);
        check("tready_backpressure_violations", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
